// File: rtl/uart_sram_ctrl.sv
// Job sequencer: streams a block of SRAM bytes through the UART loopback and
// writes each received 9-bit frame plus its error flags back to SRAM.
module uart_sram_ctrl #(
    parameter int unsigned AW          = 10,
    parameter int unsigned START_HOLD  = 64,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic          SysClk,
    input  logic          rst,
    input  logic          cmd_start,
    input  logic          cmd_abort,
    input  logic [AW-1:0] src_base,
    input  logic [AW-1:0] dst_base,
    input  logic [AW-1:0] length,
    input  logic [19:0]   frame_wait,
    input  logic [1:0]    cfg_baud,
    input  logic          cfg_parity,
    output logic [AW-1:0] sram_addr,
    output logic          sram_we,
    output logic [15:0]   sram_wdata,
    input  logic [15:0]   sram_rdata,
    output logic [7:0]    data_in,
    output logic          start_Tx,
    output logic          receive,
    output logic [1:0]    baud_selector,
    output logic          parity_sel,
    input  logic [8:0]    data_out,
    input  logic          OE,
    input  logic          BE,
    input  logic          FE,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [7:0]    err_cnt,
    output logic [AW-1:0] byte_cnt
);

    typedef enum logic [3:0] {
        StIdle, StRdReq, StRdWait, StLoad, StTx, StWait, StCapture, StWr, StFin
    } state_e;

    localparam logic [19:0] HOLD_LAST = 20'(START_HOLD - 1);

    state_e        state;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] len_q;
    logic [19:0]   fw_q;
    logic [19:0]   cnt;
    logic          cap_err;
    logic          frame_err;
    logic [AW-1:0] byte_cnt_nxt;
    logic          unused_rdata;

    assign frame_err    = OE | BE | FE;
    assign byte_cnt_nxt = byte_cnt + 1'b1;
    assign unused_rdata = ^sram_rdata[15:8];

    always_ff @(posedge SysClk or negedge rst) begin
        if (!rst) begin
            state         <= StIdle;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            len_q         <= '0;
            fw_q          <= '0;
            cnt           <= '0;
            cap_err       <= 1'b0;
            sram_addr     <= '0;
            sram_we       <= 1'b0;
            sram_wdata    <= '0;
            data_in       <= '0;
            start_Tx      <= 1'b0;
            receive       <= 1'b0;
            baud_selector <= 2'b00;
            parity_sel    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            err_cnt       <= '0;
            byte_cnt      <= '0;
        end else begin
            done    <= 1'b0;
            sram_we <= 1'b0;
            case (state)
                StIdle: begin
                    if (cmd_start) begin
                        rd_ptr        <= src_base;
                        wr_ptr        <= dst_base;
                        len_q         <= length;
                        fw_q          <= frame_wait;
                        baud_selector <= cfg_baud;
                        parity_sel    <= cfg_parity;
                        err_cnt       <= '0;
                        byte_cnt      <= '0;
                        aborted       <= 1'b0;
                        busy          <= 1'b1;
                        if (length == '0) begin
                            state <= StFin;
                        end else begin
                            sram_addr <= src_base;
                            state     <= StRdReq;
                        end
                    end
                end
                StRdReq: state <= StRdWait;
                StRdWait: begin
                    data_in <= sram_rdata[7:0];
                    receive <= 1'b1;
                    state   <= StLoad;
                end
                StLoad: begin
                    start_Tx <= 1'b1;
                    cnt      <= '0;
                    state    <= StTx;
                end
                StTx: begin
                    if (cnt == HOLD_LAST) begin
                        start_Tx <= 1'b0;
                        cnt      <= '0;
                        state    <= (fw_q == '0) ? StCapture : StWait;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StWait: begin
                    if (cnt == fw_q - 1'b1) begin
                        state <= StCapture;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StCapture: begin
                    sram_wdata <= {4'b0000, FE, BE, OE, data_out};
                    cap_err    <= frame_err;
                    if (frame_err && err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                    receive   <= 1'b0;
                    sram_we   <= 1'b1;
                    sram_addr <= wr_ptr;
                    state     <= StWr;
                end
                StWr: begin
                    rd_ptr   <= rd_ptr + 1'b1;
                    wr_ptr   <= wr_ptr + 1'b1;
                    byte_cnt <= byte_cnt_nxt;
                    if (byte_cnt_nxt == len_q || (STOP_ON_ERR && cap_err)) begin
                        aborted <= STOP_ON_ERR && cap_err;
                        state   <= StFin;
                    end else begin
                        sram_addr <= rd_ptr + 1'b1;
                        state     <= StRdReq;
                    end
                end
                StFin: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase

            // Abort overrides whatever the current state scheduled; a write
            // already strobed in WR has committed, so its counters stand.
            if (cmd_abort && state != StIdle && state != StFin) begin
                start_Tx <= 1'b0;
                receive  <= 1'b0;
                sram_we  <= 1'b0;
                aborted  <= 1'b1;
                state    <= StFin;
            end
        end
    end

endmodule

// File: tb/tb_uart_sram_ctrl.sv
// Directed bench: two controllers (STOP_ON_ERR 0 and 1) share stimulus, each
// with its own SRAM model and a behavioural UART loopback with forced flags.
module tb_uart_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_start, cmd_abort;
    logic [9:0]  src_base, dst_base, length;
    logic [19:0] frame_wait;
    logic [1:0]  cfg_baud;
    logic        cfg_parity;

    logic [9:0]  sram_addr0, sram_addr1, byte_cnt0, byte_cnt1;
    logic        sram_we0, sram_we1, start_tx0, start_tx1, receive0, receive1;
    logic [15:0] sram_wdata0, sram_wdata1, sram_rdata0, sram_rdata1;
    logic [7:0]  din0, din1, err_cnt0, err_cnt1;
    logic [1:0]  baud0, baud1;
    logic        par0, par1, busy0, busy1, done0, done1, aborted0, aborted1;
    logic [8:0]  dout0, dout1;
    logic        oe0, oe1, fe0, fe1;

    logic        pl_we;
    logic [9:0]  pl_addr;
    logic [15:0] pl_data;
    logic [15:0] mem0 [1024];
    logic [15:0] mem1 [1024];

    logic        force_oe;
    int          fe_frame;
    int          fidx0, fidx1;
    logic        tx_prev0, tx_prev1;

    int checks = 0;
    int errors = 0;

    int   cyc0, cyc1, txh, txr, rxh, wec;
    logic busy_at1, snap_rx_pre, snap_tx, snap_rx;

    always #5 clk = ~clk;

    uart_sram_ctrl #(.AW(10), .START_HOLD(4), .STOP_ON_ERR(1'b0)) dut0 (
        .SysClk(clk), .rst(rst_n), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .src_base(src_base), .dst_base(dst_base), .length(length),
        .frame_wait(frame_wait), .cfg_baud(cfg_baud), .cfg_parity(cfg_parity),
        .sram_addr(sram_addr0), .sram_we(sram_we0), .sram_wdata(sram_wdata0),
        .sram_rdata(sram_rdata0), .data_in(din0), .start_Tx(start_tx0),
        .receive(receive0), .baud_selector(baud0), .parity_sel(par0),
        .data_out(dout0), .OE(oe0), .BE(1'b0), .FE(fe0), .busy(busy0),
        .done(done0), .aborted(aborted0), .err_cnt(err_cnt0), .byte_cnt(byte_cnt0)
    );

    uart_sram_ctrl #(.AW(10), .START_HOLD(4), .STOP_ON_ERR(1'b1)) dut1 (
        .SysClk(clk), .rst(rst_n), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .src_base(src_base), .dst_base(dst_base), .length(length),
        .frame_wait(frame_wait), .cfg_baud(cfg_baud), .cfg_parity(cfg_parity),
        .sram_addr(sram_addr1), .sram_we(sram_we1), .sram_wdata(sram_wdata1),
        .sram_rdata(sram_rdata1), .data_in(din1), .start_Tx(start_tx1),
        .receive(receive1), .baud_selector(baud1), .parity_sel(par1),
        .data_out(dout1), .OE(oe1), .BE(1'b0), .FE(fe1), .busy(busy1),
        .done(done1), .aborted(aborted1), .err_cnt(err_cnt1), .byte_cnt(byte_cnt1)
    );

    // SRAM models; the pl_* port lets the bench preload both arrays.
    always @(posedge clk) begin
        if (pl_we) begin
            mem0[pl_addr] <= pl_data;
            mem1[pl_addr] <= pl_data;
        end else begin
            if (sram_we0) mem0[sram_addr0] <= sram_wdata0;
            if (sram_we1) mem1[sram_addr1] <= sram_wdata1;
        end
        sram_rdata0 <= mem0[sram_addr0];
        sram_rdata1 <= mem1[sram_addr1];
    end

    // UART loopback: frame = {parity bit, data}, parity bit = ^data ^ parity_sel.
    always @(posedge clk) begin
        if (!rst_n) begin
            tx_prev0 <= 1'b0; fidx0 <= 0; dout0 <= '0; oe0 <= 1'b0; fe0 <= 1'b0;
        end else begin
            tx_prev0 <= start_tx0;
            if (cmd_start) begin
                fidx0 <= 0;
            end else if (start_tx0 && !tx_prev0) begin
                fidx0 <= fidx0 + 1;
                dout0 <= {^din0 ^ par0, din0};
                oe0   <= force_oe;
                fe0   <= (fidx0 + 1 == fe_frame);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            tx_prev1 <= 1'b0; fidx1 <= 0; dout1 <= '0; oe1 <= 1'b0; fe1 <= 1'b0;
        end else begin
            tx_prev1 <= start_tx1;
            if (cmd_start) begin
                fidx1 <= 0;
            end else if (start_tx1 && !tx_prev1) begin
                fidx1 <= fidx1 + 1;
                dout1 <= {^din1 ^ par1, din1};
                oe1   <= force_oe;
                fe1   <= (fidx1 + 1 == fe_frame);
            end
        end
    end

    task automatic poke(input logic [9:0] a, input logic [15:0] d);
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        @(negedge clk);
        pl_we   = 1'b0;
    endtask

    // Issue one job and watch it until dut0 signals done or the budget runs out.
    task automatic run_job(input logic [9:0] src, input logic [9:0] dst,
                           input logic [9:0] len, input logic [19:0] fw,
                           input logic [1:0] baud, input logic par,
                           input int abort_at, input int restart_at, input int limit);
        logic prev_tx;
        cyc0 = 0; cyc1 = 0; txh = 0; txr = 0; rxh = 0; wec = 0;
        busy_at1 = 1'b0; snap_rx_pre = 1'b0; snap_tx = 1'b1; snap_rx = 1'b1;
        prev_tx = 1'b0;
        @(negedge clk);
        src_base = src; dst_base = dst; length = len; frame_wait = fw;
        cfg_baud = baud; cfg_parity = par; cmd_abort = 1'b0; cmd_start = 1'b1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            cmd_start = (i == restart_at);
            cmd_abort = (i == abort_at);
            if (i == restart_at) begin
                length   = 10'd1;
                cfg_baud = 2'b11;
            end
            if (i == 1) busy_at1 = busy0;
            if (i == abort_at) snap_rx_pre = receive0;
            if (i == abort_at + 1) begin
                snap_tx = start_tx0;
                snap_rx = receive0;
            end
            if (done1 && cyc1 == 0) cyc1 = i;
            if (start_tx0) txh++;
            if (start_tx0 && !prev_tx) txr++;
            prev_tx = start_tx0;
            if (receive0) rxh++;
            if (sram_we0) wec++;
            if (done0) begin
                cyc0 = i;
                break;
            end
        end
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({sram_addr0, sram_we0, sram_wdata0, din0, start_tx0, receive0, baud0, par0,
             busy0, done0, aborted0, err_cnt0, byte_cnt0} !== '0) begin
            errors++;
            $display("FAIL reset_outputs0: got addr=%0h we=%0b wd=%0h din=%0h tx=%0b rx=%0b busy=%0b done=%0b ab=%0b ec=%0d bc=%0d want all 0",
                     sram_addr0, sram_we0, sram_wdata0, din0, start_tx0, receive0, busy0,
                     done0, aborted0, err_cnt0, byte_cnt0);
        end
        checks++;
        if ({sram_addr1, sram_we1, sram_wdata1, din1, start_tx1, receive1, baud1, par1,
             busy1, done1, aborted1, err_cnt1, byte_cnt1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs1: got busy=%0b tx=%0b want all 0", busy1, start_tx1);
        end
    endtask

    task automatic test_basic;
        logic [15:0] exp [4];
        exp = '{16'h055, 16'h0A3, 16'h000, 16'h0FF};
        poke(10'h000, 16'h0055);
        poke(10'h001, 16'h00A3);
        poke(10'h002, 16'h0000);
        poke(10'h003, 16'h00FF);
        run_job(10'h000, 10'h100, 10'd4, 20'd3, 2'b01, 1'b0, 0, 0, 2000);
        checks++;
        if (cyc0 !== 50) begin errors++; $display("FAIL basic_latency: got %0d want 50", cyc0); end
        checks++;
        if (busy_at1 !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %0b want 1", busy_at1); end
        checks++;
        if (byte_cnt0 !== 10'd4) begin errors++; $display("FAIL basic_byte_cnt: got %0d want 4", byte_cnt0); end
        checks++;
        if (err_cnt0 !== 8'd0) begin errors++; $display("FAIL basic_err_cnt: got %0d want 0", err_cnt0); end
        checks++;
        if (aborted0 !== 1'b0) begin errors++; $display("FAIL basic_aborted: got %0b want 0", aborted0); end
        checks++;
        if (wec !== 4) begin errors++; $display("FAIL basic_we_cycles: got %0d want 4", wec); end
        checks++;
        if (txr !== 4 || txh !== 16) begin
            errors++; $display("FAIL basic_start_tx: got rises=%0d high=%0d want 4/16", txr, txh);
        end
        checks++;
        if (rxh !== 36) begin errors++; $display("FAIL basic_receive_cycles: got %0d want 36", rxh); end
        checks++;
        if (baud0 !== 2'b01 || busy0 !== 1'b0) begin
            errors++; $display("FAIL basic_baud_busy: got %0b/%0b want 01/0", baud0, busy0);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem0[10'h100 + k] !== exp[k]) begin
                errors++;
                $display("FAIL basic_word%0d: got %0h want %0h", k, mem0[10'h100 + k], exp[k]);
            end
        end
    endtask

    task automatic test_len0;
        run_job(10'h020, 10'h120, 10'd0, 20'd3, 2'b11, 1'b1, 0, 0, 200);
        checks++;
        if (cyc0 !== 2) begin errors++; $display("FAIL len0_latency: got %0d want 2", cyc0); end
        checks++;
        if (aborted0 !== 1'b0 || byte_cnt0 !== 10'd0) begin
            errors++; $display("FAIL len0_status: got ab=%0b bc=%0d want 0/0", aborted0, byte_cnt0);
        end
        checks++;
        if (wec !== 0 || txr !== 0) begin
            errors++; $display("FAIL len0_activity: got we=%0d tx=%0d want 0/0", wec, txr);
        end
        checks++;
        if (baud0 !== 2'b11 || par0 !== 1'b1) begin
            errors++; $display("FAIL len0_cfg_latch: got %0b/%0b want 11/1", baud0, par0);
        end
    endtask

    task automatic test_wrap;
        logic [15:0] exp [3];
        exp = '{16'h001, 16'h17E, 16'h155};
        poke(10'h3FE, 16'h0001);
        poke(10'h3FF, 16'h007E);
        run_job(10'h3FE, 10'h200, 10'd3, 20'd0, 2'b10, 1'b1, 0, 0, 2000);
        checks++;
        if (cyc0 !== 29) begin errors++; $display("FAIL wrap_latency: got %0d want 29", cyc0); end
        checks++;
        if (rxh !== 18) begin errors++; $display("FAIL wrap_receive_cycles: got %0d want 18", rxh); end
        checks++;
        if (byte_cnt0 !== 10'd3 || baud0 !== 2'b10 || par0 !== 1'b1) begin
            errors++;
            $display("FAIL wrap_status: got bc=%0d baud=%0b par=%0b want 3/10/1", byte_cnt0, baud0, par0);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (mem0[10'h200 + k] !== exp[k]) begin
                errors++;
                $display("FAIL wrap_word%0d: got %0h want %0h", k, mem0[10'h200 + k], exp[k]);
            end
        end
    endtask

    task automatic test_abort;
        poke(10'h010, 16'h0011);
        poke(10'h011, 16'h0022);
        poke(10'h012, 16'h0033);
        poke(10'h302, 16'hBEEF);
        // Frame 3 WAIT spans cycles 38..43 with frame_wait=6; abort at 40.
        run_job(10'h010, 10'h300, 10'd5, 20'd6, 2'b01, 1'b0, 40, 5, 2000);
        checks++;
        if (snap_rx_pre !== 1'b1) begin errors++; $display("FAIL abort_in_frame: got rx=%0b want 1", snap_rx_pre); end
        checks++;
        if (snap_tx !== 1'b0 || snap_rx !== 1'b0) begin
            errors++; $display("FAIL abort_next_cycle: got tx=%0b rx=%0b want 0/0", snap_tx, snap_rx);
        end
        checks++;
        if (cyc0 !== 42) begin errors++; $display("FAIL abort_done_cycle: got %0d want 42", cyc0); end
        checks++;
        if (aborted0 !== 1'b1 || byte_cnt0 !== 10'd2) begin
            errors++; $display("FAIL abort_status: got ab=%0b bc=%0d want 1/2", aborted0, byte_cnt0);
        end
        checks++;
        if (wec !== 2 || mem0[10'h302] !== 16'hBEEF) begin
            errors++; $display("FAIL abort_no_write: got we=%0d word=%0h want 2/beef", wec, mem0[10'h302]);
        end
        checks++;
        if (mem0[10'h301] !== 16'h022) begin
            errors++; $display("FAIL abort_word1: got %0h want 22", mem0[10'h301]);
        end
        checks++;
        if (baud0 !== 2'b01) begin
            errors++; $display("FAIL abort_restart_ignored: got baud=%0b want 01", baud0);
        end
    endtask

    task automatic test_reset_mid;
        int dn;
        dn = 0;
        @(negedge clk);
        src_base = 10'h000; dst_base = 10'h3C0; length = 10'd4; frame_wait = 20'd3;
        cfg_baud = 2'b01; cfg_parity = 1'b0; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (receive0 !== 1'b1) begin errors++; $display("FAIL rstmid_running: got rx=%0b want 1", receive0); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy0, receive0, start_tx0, sram_addr0, din0, baud0} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got busy=%0b rx=%0b tx=%0b addr=%0h want 0", busy0,
                     receive0, start_tx0, sram_addr0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (done0) dn++;
        end
        checks++;
        if (dn !== 0 || mem0[10'h3C0] !== 16'h0) begin
            errors++; $display("FAIL rstmid_no_done: got done=%0d word=%0h want 0/0", dn, mem0[10'h3C0]);
        end
    endtask

    task automatic test_err_stop;
        fe_frame = 2;
        run_job(10'h000, 10'h380, 10'd5, 20'd3, 2'b00, 1'b0, 0, 0, 2000);
        fe_frame = 0;
        checks++;
        if (cyc1 !== 26) begin errors++; $display("FAIL errstop_latency: got %0d want 26", cyc1); end
        checks++;
        if (aborted1 !== 1'b1 || byte_cnt1 !== 10'd2 || err_cnt1 !== 8'd1) begin
            errors++;
            $display("FAIL errstop_status: got ab=%0b bc=%0d ec=%0d want 1/2/1", aborted1, byte_cnt1, err_cnt1);
        end
        checks++;
        if (mem1[10'h381] !== 16'h8A3 || mem1[10'h382] !== 16'h0) begin
            errors++;
            $display("FAIL errstop_words: got %0h/%0h want 8a3/0", mem1[10'h381], mem1[10'h382]);
        end
        checks++;
        if (cyc0 !== 62 || aborted0 !== 1'b0 || byte_cnt0 !== 10'd5 || err_cnt0 !== 8'd1) begin
            errors++;
            $display("FAIL errcont_status: got cyc=%0d ab=%0b bc=%0d ec=%0d want 62/0/5/1", cyc0,
                     aborted0, byte_cnt0, err_cnt0);
        end
    endtask

    task automatic test_err_saturate;
        force_oe = 1'b1;
        run_job(10'h000, 10'h000, 10'd300, 20'd1, 2'b00, 1'b0, 0, 0, 5000);
        force_oe = 1'b0;
        checks++;
        if (cyc0 !== 3002) begin errors++; $display("FAIL sat_latency: got %0d want 3002", cyc0); end
        checks++;
        if (err_cnt0 !== 8'd255) begin errors++; $display("FAIL sat_err_cnt: got %0d want 255", err_cnt0); end
        checks++;
        if (byte_cnt0 !== 10'd300 || wec !== 300) begin
            errors++; $display("FAIL sat_frames: got bc=%0d we=%0d want 300/300", byte_cnt0, wec);
        end
        checks++;
        if (mem0[10'h000] !== 16'h255 || mem0[10'h001] !== 16'h2A3) begin
            errors++; $display("FAIL sat_words: got %0h/%0h want 255/2a3", mem0[10'h000], mem0[10'h001]);
        end
        checks++;
        if (aborted1 !== 1'b1 || byte_cnt1 !== 10'd1 || err_cnt1 !== 8'd1) begin
            errors++;
            $display("FAIL sat_stop_first: got ab=%0b bc=%0d ec=%0d want 1/1/1", aborted1, byte_cnt1, err_cnt1);
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_start = 1'b0; cmd_abort = 1'b0;
        src_base = '0; dst_base = '0; length = '0; frame_wait = '0;
        cfg_baud = 2'b00; cfg_parity = 1'b0;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        force_oe = 1'b0; fe_frame = 0;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) poke(10'(i), 16'h0000);
        test_reset;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_basic;
        test_len0;
        test_wrap;
        test_abort;
        test_reset_mid;
        test_err_stop;
        test_err_saturate;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_sram_ctrl.md
# uart_sram_ctrl

Job sequencer that moves a block of bytes from SRAM through the UART loopback (UART_TOP) and writes each received 9-bit word, plus error flags, back to SRAM. It sits between the host/command logic, the single-port synchronous SRAM and UART_TOP, and it is the only driver of UART_TOP's `data_in`, `start_Tx`, `receive`, `parity_sel` and `baud_selector`. All logic runs on SysClk. The baud-domain timing is covered by a programmable per-frame wait count.

## Interface
- AW, 10, SRAM address width
- START_HOLD, 64, SysClk cycles `start_Tx` is held high; must be at least one baud_clk period
- STOP_ON_ERR, 0, 1 = end the job at the first frame with OE/BE/FE set
- SysClk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cmd_start  in  1  single-cycle job request; ignored while `busy`
- cmd_abort  in  1  terminate the current job
- src_base  in  AW  first SRAM read address
- dst_base  in  AW  first SRAM write address
- length  in  AW  number of bytes in the job
- frame_wait  in  20  SysClk cycles from `start_Tx` fall to data capture
- cfg_baud  in  2  baud select; latched at job start
- cfg_parity  in  1  parity select; latched at job start
- sram_addr  out  AW  SRAM address
- sram_we  out  1  SRAM write strobe
- sram_wdata  out  16  write data: {4'b0, FE, BE, OE, data_out[8:0]}
- sram_rdata  in  16  read data; bits [7:0] used; valid 1 cycle after address
- data_in  out  8  to UART_TOP
- start_Tx  out  1  to UART_TOP
- receive  out  1  to UART_TOP
- baud_selector  out  2  to UART_TOP
- parity_sel  out  1  to UART_TOP
- data_out  in  9  from UART_TOP
- OE, BE, FE  in  1 each  from UART_TOP
- busy  out  1  job in progress
- done  out  1  single-cycle pulse at job end
- aborted  out  1  valid with `done`: the job ended by abort or by error stop
- err_cnt  out  8  frames with any error flag; saturates at 255; cleared at job start
- byte_cnt  out  AW  frames completed in the current or last job

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, LOAD, TX, WAIT, CAPTURE, WR, FIN.
- IDLE: on `cmd_start`, latch bases, length, frame_wait, cfg_baud and cfg_parity. Clear err_cnt and byte_cnt. Go to FIN if length==0, otherwise go to RD_REQ.
- RD_REQ: drive `sram_addr` = rd_ptr.
- RD_WAIT: wait for the 1-cycle SRAM read latency.
- LOAD: register sram_rdata[7:0] into `data_in` and assert `receive`.
- TX: hold `start_Tx` high for START_HOLD cycles.
- WAIT: count frame_wait cycles.
- CAPTURE: register data_out, OE, BE and FE. If any flag is set, increment err_cnt (saturating).
- WR: drive `sram_we`=1 with `sram_addr`=wr_ptr. Deassert `receive`. Increment rd_ptr, wr_ptr and byte_cnt.
  - Go to FIN if byte_cnt reaches length, or if STOP_ON_ERR=1 and the captured frame had an error (aborted=1).
  - Otherwise go to RD_REQ.
- FIN: pulse `done`, drop `busy`, return to IDLE.
- Pointers wrap modulo 2^AW. Source and destination regions may overlap; each read always precedes that frame's write.
- `cmd_abort` in any non-IDLE state other than FIN:
  - next cycle: start_Tx=0, receive=0, sram_we=0, state=FIN, aborted=1;
  - a frame interrupted before WR is not written.
- `cmd_abort` and `cmd_start` in the same cycle while IDLE: the start is accepted; the abort is ignored.
- `baud_selector`/`parity_sel` stay constant from job start until the next accepted `cmd_start`.

## Timing
- Reset values of outputs:
  - sram_addr, sram_we, sram_wdata, data_in, start_Tx, receive, busy, done, aborted, err_cnt, byte_cnt: 0;
  - baud_selector: 2'b00, parity_sel: 0;
  - state: IDLE.
- `busy` rises the cycle after `cmd_start` is accepted.
- Per-frame latency: 1+1+1+START_HOLD+frame_wait+1+1 = START_HOLD+frame_wait+5 cycles.
- Job latency: length×(START_HOLD+frame_wait+5), plus 2 cycles (accept + FIN) from `cmd_start` to `done`.
- length==0: `done` is asserted 2 cycles after `cmd_start`, with no SRAM access and no `start_Tx`.
- `receive` is high from LOAD through CAPTURE inclusive.
- `sram_we` is high for exactly 1 cycle per frame.
- frame_wait==0: WAIT lasts 0 cycles (TX goes directly to CAPTURE).
- Reset asserted mid-job: all outputs go to reset values immediately. No `done` is produced.

## Test plan
- Reset check: reset asserted -> all outputs 0 and busy=0. Then src_base=0, dst_base=0x100, length=4, SRAM[0..3]=0x55,0xA3,0x00,0xFF, parity even -> SRAM[0x100..0x103] hold the 9-bit frames, err_cnt=0, byte_cnt=4, done after 4×(START_HOLD+frame_wait+5)+2 cycles.
- length=0 -> done=1 two cycles after cmd_start, aborted=0, no sram_we, no start_Tx.
- Wrap: src_base=0x3FE, length=3 -> reads at 0x3FE, 0x3FF, 0x000.
- Error stop: frame_wait forced too short so FE=1 on frame 2, STOP_ON_ERR=1, length=5 -> done with aborted=1, byte_cnt=2, err_cnt=1.
- Abort: cmd_abort during WAIT of frame 3 -> start_Tx=0 and receive=0 the next cycle, done with aborted=1, byte_cnt=2, no third write. A second cmd_start issued while busy -> ignored.
- err_cnt saturation: 300 frames with OE forced -> err_cnt=255.
